// File: rtl/display_capture.sv
// Captures a multiplexed 4-digit display bus into a 16-bit word.
// A digit counts once it has been seen on two consecutive samples; digits assemble in order 0..3.
module display_capture #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk0,
  input  logic        rst,
  input  logic        ena,
  input  logic [3:0]  sel_in,
  input  logic [3:0]  dig_in,
  output logic [15:0] word,
  output logic        valid,
  output logic        err,
  output logic        blank
);

  typedef enum logic [1:0] {Exp0, Exp1, Exp2, Exp3} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q;
  logic [3:0]  sel_q, sel_p, dig_q, dig_p;
  logic        run_acc_q;
  logic [11:0] shadow_q;
  logic [7:0]  cnt_q, cnt_d;

  logic        legal_q, illegal_q, illegal_p, same, accept, timeout_d;
  logic [1:0]  idx_q;

  function automatic logic sel_illegal(input logic [3:0] s);
    return (s != 4'hF) && !$onehot(~s);
  endfunction

  always_comb begin
    legal_q = 1'b1;
    idx_q   = 2'd0;
    case (sel_q)
      4'b1110: idx_q = 2'd0;
      4'b1101: idx_q = 2'd1;
      4'b1011: idx_q = 2'd2;
      4'b0111: idx_q = 2'd3;
      default: legal_q = 1'b0;
    endcase
  end

  assign illegal_q = sel_illegal(sel_q);
  assign illegal_p = sel_illegal(sel_p);
  assign same      = (sel_q == sel_p) && (dig_q == dig_p);
  // run_acc_q marks that the run ending in the p sample has already produced its accept.
  assign accept    = legal_q && same && !run_acc_q;

  always_comb begin
    cnt_d = 8'd0;
    if (sel_in == 4'hF) begin
      cnt_d = (cnt_q >= TimeoutCnt) ? cnt_q : cnt_q + 8'd1;
    end
  end

  assign timeout_d = (cnt_d == TimeoutCnt);

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      sel_q     <= 4'hF;
      sel_p     <= 4'hF;
      dig_q     <= 4'h0;
      dig_p     <= 4'h0;
      run_acc_q <= 1'b0;
      shadow_q  <= 12'h000;
      word      <= 16'h0000;
      cnt_q     <= 8'd0;
      state_q   <= Exp0;
      valid     <= 1'b0;
      err       <= 1'b0;
      blank     <= 1'b0;
    end else if (!ena) begin
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid     <= 1'b0;
      err       <= 1'b0;
      sel_q     <= sel_in;
      dig_q     <= dig_in;
      sel_p     <= sel_q;
      dig_p     <= dig_q;
      run_acc_q <= accept | (run_acc_q & same);
      cnt_q     <= cnt_d;
      blank     <= timeout_d;

      if (illegal_q) begin
        // Only the first sample of an illegal run is reported.
        state_q <= Exp0;
        err     <= !illegal_p;
      end else if (timeout_d) begin
        state_q <= Exp0;
      end else if (accept) begin
        if (state_e'(idx_q) == state_q) begin
          if (idx_q == 2'd3) begin
            word    <= {dig_q, shadow_q};
            valid   <= 1'b1;
            state_q <= Exp0;
          end else begin
            shadow_q[{idx_q, 2'b00} +: 4] <= dig_q;
            state_q <= state_e'(idx_q + 2'd1);
          end
        end else begin
          err <= 1'b1;
          if (idx_q == 2'd0) begin
            shadow_q[3:0] <= dig_q;
            state_q       <= Exp1;
          end else begin
            state_q <= Exp0;
          end
        end
      end
    end
  end

endmodule
